instr_fetch_decode: RTL and testbench



---
 rtl/instr_fetch_decode.sv | 112 +++++++++++
 tb/tb_instr_fetch_decode.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_decode.sv
// rtl/instr_fetch_decode.sv - instruction fetch and decode stage, one instruction in flight
module instr_fetch_decode #(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [PC_WIDTH-1:0] imem_addr,
    output logic                imem_req,
    input  logic [15:0]         imem_rdata,
    input  logic                imem_ack,
    input  logic                jump_en,
    input  logic [PC_WIDTH-1:0] jump_addr,
    input  logic                stall,
    output logic                dec_valid,
    output logic [3:0]          dec_opcode,
    output logic [2:0]          dec_op1_regaddr,
    output logic [2:0]          dec_op2_regaddr,
    output logic [15:0]         dec_imm,
    output logic [PC_WIDTH-1:0] dec_pc
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH1 = 2'd1,
        S_FETCH2 = 2'd2,
        S_ISSUE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] dec_pc_q, dec_pc_d;
    logic [15:0]         instr_q, instr_d;
    logic [15:0]         imm_q, imm_d;
    logic                two_word;

    // MVI (1100) and LDA (1101) carry a trailing immediate word
    assign two_word = (imem_rdata[15:13] == 3'b110);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            dec_pc_q <= RESET_PC;
            instr_q  <= 16'h0000;
            imm_q    <= 16'h0000;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            dec_pc_q <= dec_pc_d;
            instr_q  <= instr_d;
            imm_q    <= imm_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        dec_pc_d = dec_pc_q;
        instr_d  = instr_q;
        imm_d    = imm_q;
        // A redirect beats any same-cycle ack and drops whatever was partially fetched
        if (jump_en && (state_q != S_IDLE)) begin
            pc_d    = jump_addr;
            state_d = S_FETCH1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_FETCH1;
                end
                S_FETCH1: begin
                    if (imem_ack) begin
                        instr_d  = imem_rdata;
                        dec_pc_d = pc_q;
                        pc_d     = pc_q + PC_WIDTH'(1);
                        if (two_word) begin
                            state_d = S_FETCH2;
                        end else begin
                            imm_d   = 16'h0000;
                            state_d = S_ISSUE;
                        end
                    end
                end
                S_FETCH2: begin
                    if (imem_ack) begin
                        imm_d   = imem_rdata;
                        pc_d    = pc_q + PC_WIDTH'(1);
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!stall) begin
                        state_d = S_FETCH1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign imem_req        = (state_q == S_FETCH1) || (state_q == S_FETCH2);
    assign imem_addr       = pc_q;
    assign dec_valid       = (state_q == S_ISSUE);
    assign dec_opcode      = instr_q[15:12];
    assign dec_op1_regaddr = instr_q[11:9];
    assign dec_op2_regaddr = instr_q[8:6];
    assign dec_imm         = imm_q;
    assign dec_pc          = dec_pc_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb/tb_instr_fetch_decode.sv - scoreboard bench for instr_fetch_decode
module tb_instr_fetch_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  imem_addr;
    logic        imem_req;
    logic [15:0] imem_rdata;
    logic        imem_ack;
    logic        jump_en;
    logic [7:0]  jump_addr;
    logic        stall;
    logic        dec_valid;
    logic [3:0]  dec_opcode;
    logic [2:0]  dec_op1_regaddr;
    logic [2:0]  dec_op2_regaddr;
    logic [15:0] dec_imm;
    logic [7:0]  dec_pc;

    always #5 clk = ~clk;

    instr_fetch_decode #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_addr       (imem_addr),
        .imem_req        (imem_req),
        .imem_rdata      (imem_rdata),
        .imem_ack        (imem_ack),
        .jump_en         (jump_en),
        .jump_addr       (jump_addr),
        .stall           (stall),
        .dec_valid       (dec_valid),
        .dec_opcode      (dec_opcode),
        .dec_op1_regaddr (dec_op1_regaddr),
        .dec_op2_regaddr (dec_op2_regaddr),
        .dec_imm         (dec_imm),
        .dec_pc          (dec_pc)
    );

    typedef struct packed {
        logic [3:0]  op;
        logic [2:0]  r1;
        logic [2:0]  r2;
        logic [15:0] imm;
        logic [7:0]  pc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [15:0] mem [256];
    logic [7:0]  next_pc;
    int checks = 0;
    int errors = 0;
    int transfers = 0;
    int ack_delay = 0;
    int waited = 0;
    int stall_pct = 0;
    int jump_pct = 0;
    int stall_hold = 0;
    int jump_in = 0;
    logic [7:0] jump_tgt = 8'h00;
    int t0;
    logic ok;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic bit pct(input int p);
        return int'($urandom_range(99, 0)) < p;
    endfunction

    // Reference: the instruction starting at address a, and where the following one starts
    function automatic void push_instr(input logic [7:0] a);
        exp_t        e;
        logic [15:0] w;
        w    = mem[a];
        e.op = w[15:12];
        e.r1 = w[11:9];
        e.r2 = w[8:6];
        e.pc = a;
        if (w[15:12] == 4'hC || w[15:12] == 4'hD) begin
            e.imm   = mem[a + 8'd1];
            next_pc = a + 8'd2;
        end else begin
            e.imm   = 16'h0000;
            next_pc = a + 8'd1;
        end
        exp_q.push_back(e);
    endfunction

    function automatic void do_jump(input logic abort);
        logic [7:0] tgt;
        tgt       = (jump_in != 0) ? jump_tgt : 8'($urandom);
        jump_en   = 1'b1;
        jump_addr = tgt;
        if (abort) void'(exp_q.pop_back());
        push_instr(tgt);
        jump_in = 0;
        waited  = 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        jump_en    = 1'b0;
        imem_ack   = 1'b0;
        stall      = 1'b0;
        imem_rdata = 16'($urandom);
        if (dec_valid) begin
            imem_ack = pct(30);
            if (stall_hold > 0) begin
                stall = 1'b1;
                stall_hold--;
            end else begin
                stall = pct(stall_pct);
            end
            if (jump_in == 2 || (jump_in == 0 && pct(jump_pct))) do_jump(stall);
            else if (!stall) push_instr(next_pc);
        end else if (imem_req) begin
            if (ack_delay < 0) imem_ack = pct(55);
            else imem_ack = (waited >= ack_delay);
            if (imem_ack) begin
                imem_rdata = mem[imem_addr];
                waited     = 0;
            end else begin
                waited++;
            end
            if (jump_in == 1 || (jump_in == 0 && pct(jump_pct))) do_jump(1'b1);
        end else begin
            imem_ack = pct(30);
        end
    endtask

    task automatic wait_valid(input string name);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            ok = dec_valid;
        end
        check(name, ok, 1);
    endtask

    task automatic wait_fetch(input string name, input logic [7:0] a);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            ok = imem_req && (imem_addr == a);
        end
        check(name, ok, 1);
    endtask

    // Scoreboard monitor: every presented instruction must match the head of the queue
    always @(negedge clk) begin
        if (rst_n && dec_valid && !(jump_en && stall)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue actual pc=%0h required no instruction", dec_pc);
            end else begin
                mon_e = exp_q[0];
                check("dec_opcode", dec_opcode, mon_e.op);
                check("dec_op1", dec_op1_regaddr, mon_e.r1);
                check("dec_op2", dec_op2_regaddr, mon_e.r2);
                check("dec_imm", dec_imm, mon_e.imm);
                check("dec_pc", dec_pc, mon_e.pc);
                if (!stall) begin
                    void'(exp_q.pop_front());
                    transfers++;
                end
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        jump_en    = 1'b0;
        jump_addr  = 8'h00;
        stall      = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[8'h00] = 16'hB280;
        mem[8'h01] = 16'hC600;
        mem[8'h02] = 16'h1234;
        mem[8'h03] = 16'hD000;
        mem[8'h04] = 16'hBEEF;
        mem[8'h05] = 16'hC000;
        mem[8'h06] = 16'h5555;
        mem[8'h40] = 16'h1280;
        mem[8'hFF] = 16'hD000;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req", imem_req, 0);
        check("rst_valid", dec_valid, 0);
        check("rst_addr", imem_addr, 8'h00);
        check("rst_opcode", dec_opcode, 0);
        check("rst_imm", dec_imm, 0);
        check("rst_pc", dec_pc, 8'h00);

        rst_n = 1'b1;
        push_instr(8'h00);
        check("idle_req", imem_req, 0);
        tick();
        check("first_req", imem_req, 1);
        check("first_addr", imem_addr, 8'h00);
        tick();
        check("mov_valid", dec_valid, 1);
        tick();
        check("mov_next_addr", imem_addr, 8'h01);
        tick();
        tick();
        check("mvi_valid", dec_valid, 1);
        ack_delay = 3;
        tick();
        check("mvi_next_addr", imem_addr, 8'h03);
        check("mvi_one_transfer", transfers, 2);

        t0         = transfers;
        stall_hold = 4;
        wait_valid("lda_valid");
        ack_delay = 0;
        wait_fetch("lda_done", 8'h05);
        check("lda_single_transfer", transfers, t0 + 1);

        jump_in  = 1;
        jump_tgt = 8'h40;
        tick();
        check("fetch2_addr", imem_addr, 8'h06);
        tick();
        check("jump_req", imem_req, 1);
        check("jump_target", imem_addr, 8'h40);

        mem[8'h00] = 16'h00AA;
        jump_in    = 2;
        jump_tgt   = 8'hFF;
        wait_valid("j40_valid");
        wait_valid("wrap_valid");
        tick();
        check("wrap_next_addr", imem_addr, 8'h01);

        stall_hold = 10;
        wait_valid("pre_reset_valid");
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", dec_valid, 0);
        check("async_req", imem_req, 0);
        check("async_addr", imem_addr, 8'h00);
        exp_q.delete();
        stall_hold = 0;
        stall      = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_instr(8'h00);
        tick();
        check("restart_req", imem_req, 1);
        check("restart_addr", imem_addr, 8'h00);

        ack_delay = -1;
        stall_pct = 30;
        jump_pct  = 6;
        t0        = transfers;
        for (int c = 0; c < 4000; c++) tick();
        stall_pct = 0;
        jump_pct  = 0;
        @(negedge clk);
        #1;
        check("pending_depth", exp_q.size(), 1);
        check("random_progress", (transfers - t0) > 100, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
